// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Brief    : Launches NUM_STAGES pipeline stages in order, one start/done
//            handshake each, with a per-stage watchdog and sticky fault report.
//            Optional per-stage cycle counters enabled by LAYER_SEQ_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int SW             = (NUM_STAGES <= 1) ? 1 : $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [SW-1:0]         err_stage,
  output logic [SW-1:0]         cur_stage,
  input  logic [SW-1:0]         perf_sel,
  output logic [31:0]           perf_cycles
);

  localparam int            c_WDW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] c_LAST = SW'(NUM_STAGES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_WDW-1:0]      r_wdog;
  logic [NUM_STAGES-1:0] w_cur_oh;
  logic                  w_valid;
  logic                  w_spur;
  logic                  w_expired;
  logic                  w_accept;
  logic [1:0]            w_code;

  // Fault priority: abort, then spurious done; a valid done beats expiry.
  always_comb begin
    w_cur_oh  = NUM_STAGES'(1) << cur_stage;
    w_valid   = |(stage_done & w_cur_oh);
    w_spur    = |(stage_done & ~w_cur_oh);
    w_expired = (r_wdog >= c_WDW'(TIMEOUT_CYCLES));
    w_accept  = (r_state == ST_IDLE) && start && !abort;
    if (abort)
      w_code = 2'b11;
    else if (w_spur)
      w_code = 2'b10;
    else if (!w_valid && w_expired)
      w_code = 2'b01;
    else
      w_code = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wdog      <= '0;
      stage_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'b00;
      err_stage   <= '0;
      cur_stage   <= '0;
    end else begin
      stage_start <= '0;
      done        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_RUN;
            busy        <= 1'b1;
            cur_stage   <= '0;
            error       <= 1'b0;
            err_code    <= 2'b00;
            err_stage   <= '0;
            r_wdog      <= '0;
            stage_start <= NUM_STAGES'(1);
          end
        end
        ST_RUN: begin
          r_wdog <= r_wdog + 1'b1;
          if (w_code != 2'b00) begin
            r_state   <= ST_IDLE;
            busy      <= 1'b0;
            error     <= 1'b1;
            err_code  <= w_code;
            err_stage <= cur_stage;
          end else if (w_valid) begin
            r_wdog <= '0;
            if (cur_stage == c_LAST) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              cur_stage   <= cur_stage + 1'b1;
              stage_start <= w_cur_oh << 1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  // Sized to the full select range so any perf_sel reads a defined entry.
  localparam int c_PN = 1 << SW;

  logic [31:0] r_perf [c_PN];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_PN; i++) r_perf[i] <= '0;
      perf_cycles <= '0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < c_PN; i++) r_perf[i] <= '0;
      end else if (r_state == ST_RUN && r_perf[cur_stage] != '1) begin
        r_perf[cur_stage] <= r_perf[cur_stage] + 1'b1;
      end
      perf_cycles <= r_perf[perf_sel];
    end
  end
`else
  logic w_unused_perf_sel;
  assign w_unused_perf_sel = ^perf_sel;
  assign perf_cycles       = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_sequencer
// Brief    : Scoreboard bench for layer_sequencer; auto-responding stages.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

  localparam int NS  = 3;
  localparam int TO  = 16;
  localparam int SWB = 2;

  logic            clk = 1'b0;
  logic            reset, start, abort;
  logic [NS-1:0]   stage_start, stage_done;
  logic [NS-1:0]   auto_done = '0;
  logic [NS-1:0]   man_done  = '0;
  logic            busy, done, error;
  logic [1:0]      err_code;
  logic [SWB-1:0]  err_stage, cur_stage, perf_sel;
  logic [31:0]     perf_cycles;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;
  int lat[NS];
  int cnt[NS];

  typedef struct {
    int c;
    int kind;
    int val;
  } ev_t;
  ev_t exp_q[$];

  assign stage_done = auto_done | man_done;

  layer_sequencer #(
    .NUM_STAGES    (NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .stage_start(stage_start),
    .stage_done (stage_done),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .err_stage  (err_stage),
    .cur_stage  (cur_stage),
    .perf_sel   (perf_sel),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stage model: stage i returns done lat[i] cycles after its pulse (<0: never).
  always @(posedge clk) begin
    #1;
    auto_done = '0;
    for (int i = 0; i < NS; i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          auto_done[i] = 1'b1;
          cnt[i] = -1;
        end
      end
      if (stage_start[i] === 1'b1 && lat[i] >= 0) begin
        if (lat[i] == 0) auto_done[i] = 1'b1;
        else cnt[i] = lat[i];
      end
    end
  end

  // Every stage_start/done pulse is matched in order against the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    int  v;
    for (int k = 0; k < 2; k++) begin
      if ((k == 0 && stage_start != '0) || (k == 1 && done === 1'b1)) begin
        v = (k == 0) ? int'(stage_start) : 1;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL event: unexpected kind=%0d val=%0d at cycle %0d, expected none",
                   k, v, cyc - base);
        end else begin
          e = exp_q.pop_front();
          if (e.c != cyc - base || e.kind != k || e.val != v) begin
            bad++;
            $display("FAIL event: got kind=%0d val=%0d cycle=%0d, expected kind=%0d val=%0d cycle=%0d",
                     k, v, cyc - base, e.kind, e.val, e.c);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input int c, input int kind, input int val);
    exp_q.push_back('{c, kind, val});
  endtask

  // Expected pulse schedule from stage latencies; returns the done cycle.
  task automatic push_run(input int l0, input int l1, input int l2, output int pd);
    int p;
    lat = '{l0, l1, l2};
    p = 1;
    for (int i = 0; i < NS; i++) begin
      push_ev(p, 0, 1 << i);
      p = p + lat[i] + 1;
    end
    push_ev(p, 1, 1);
    pd = p;
  endtask

  task automatic kick();
    start = 1'b1;
    base  = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [46:0] outs;
    reset = 1'b1; start = 1'b0; abort = 1'b0; man_done = '0; perf_sel = '0;
    tick(3);
    outs = {stage_start, busy, done, error, err_code, err_stage, cur_stage, perf_cycles};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, expected 0", outs);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_normal();
    int pd;
    int lv[NS];
    int ep;
    lv = '{5, 10, 3};
    push_run(lv[0], lv[1], lv[2], pd);
    kick();
    for (int k = 1; k <= pd + 2; k++) begin
      total++;
      if (busy !== (k < pd)) begin
        bad++;
        $display("FAIL normal_busy: cycle %0d got %b, expected %b", k, busy, (k < pd));
      end
      tick(1);
    end
    total++;
    if (error !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL normal_end: error=%b pending=%0d, expected error=0 pending=0", error, exp_q.size());
    end
    for (int i = 0; i < NS; i++) begin
      perf_sel = SWB'(i);
      tick(1);
`ifdef LAYER_SEQ_PERF_EN
      ep = lv[i] + 1;
`else
      ep = 0;
`endif
      total++;
      if (perf_cycles !== 32'(ep)) begin
        bad++;
        $display("FAIL perf_cycles[%0d]: got %0d, expected %0d", i, perf_cycles, ep);
      end
    end
  endtask

  task automatic test_timeout();
    int fc;
    lat = '{2, -1, 0};
    push_ev(1, 0, 1);
    push_ev(4, 0, 2);
    fc = 4 + TO + 1;
    kick();
    for (int k = 1; k <= fc + 4; k++) begin
      total++;
      if (busy !== (k < fc) || error !== (k >= fc)) begin
        bad++;
        $display("FAIL timeout_flags: cycle %0d busy=%b error=%b, expected busy=%b error=%b",
                 k, busy, error, (k < fc), (k >= fc));
      end
      tick(1);
    end
    total++;
    if (err_code !== 2'b01 || err_stage !== 2'd1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL timeout_code: code=%b stage=%0d pending=%0d, expected code=01 stage=1 pending=0",
               err_code, err_stage, exp_q.size());
    end
  endtask

  task automatic test_boundary();
    int pd;
    push_run(TO, 0, 0, pd);
    kick();
    tick(pd);
    total++;
    if (busy !== 1'b0 || error !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL boundary: busy=%b error=%b pending=%0d, expected busy=0 error=0 pending=0",
               busy, error, exp_q.size());
    end
  endtask

  task automatic test_spurious();
    lat = '{-1, 0, 0};
    push_ev(1, 0, 1);
    kick();
    tick(2);
    man_done = 3'b100;
    tick(1);
    man_done = '0;
    total++;
    if (busy !== 1'b0 || error !== 1'b1 || err_code !== 2'b10 || err_stage !== 2'd0) begin
      bad++;
      $display("FAIL spurious_fault: busy=%b error=%b code=%b stage=%0d, expected busy=0 error=1 code=10 stage=0",
               busy, error, err_code, err_stage);
    end
    tick(1);
    man_done = 3'b001;
    tick(1);
    man_done = '0;
    tick(3);
    total++;
    if (busy !== 1'b0 || error !== 1'b1 || err_code !== 2'b10 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL spurious_late_done: busy=%b error=%b code=%b pending=%0d, expected busy=0 error=1 code=10 pending=0",
               busy, error, err_code, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int pd;
    lat = '{2, 5, 1};
    push_ev(1, 0, 1);
    push_ev(4, 0, 2);
    kick();
    tick(8);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || error !== 1'b1 || err_code !== 2'b11 || err_stage !== 2'd1) begin
      bad++;
      $display("FAIL abort_fault: busy=%b error=%b code=%b stage=%0d, expected busy=0 error=1 code=11 stage=1",
               busy, error, err_code, err_stage);
    end
    tick(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL abort_pending: got %0d, expected 0", exp_q.size());
    end
    push_run(5, 10, 3, pd);
    kick();
    total++;
    if (error !== 1'b0 || err_code !== 2'b00 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_restart: error=%b code=%b busy=%b, expected error=0 code=00 busy=1",
               error, err_code, busy);
    end
    tick(pd);
    total++;
    if (busy !== 1'b0 || error !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL abort_rerun: busy=%b error=%b pending=%0d, expected busy=0 error=0 pending=0",
               busy, error, exp_q.size());
    end
  endtask

  task automatic test_misuse();
    int pd;
    logic [46:0] outs;
    man_done = 3'b111;
    tick(1);
    man_done = '0;
    tick(2);
    total++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL idle_done: busy=%b error=%b, expected busy=0 error=0", busy, error);
    end
    push_run(5, 10, 3, pd);
    kick();
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(pd - 8);
    total++;
    if (busy !== 1'b0 || error !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL busy_start: busy=%b error=%b pending=%0d, expected busy=0 error=0 pending=0",
               busy, error, exp_q.size());
    end
    lat = '{-1, 0, 0};
    push_ev(1, 0, 1);
    kick();
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    outs = {stage_start, busy, done, error, err_code, err_stage, cur_stage, perf_cycles};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL midrun_reset: got %h, expected 0", outs);
    end
    tick(3);
    total++;
    if (busy !== 1'b0 || error !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL post_reset: busy=%b error=%b pending=%0d, expected busy=0 error=0 pending=0",
               busy, error, exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      cnt[i] = -1;
      lat[i] = -1;
    end
    reset = 1'b1; start = 1'b0; abort = 1'b0; perf_sel = '0;
    test_reset();
    test_normal();
    test_timeout();
    test_boundary();
    test_spurious();
    test_abort();
    test_misuse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
`default_nettype wire
